// File: rtl/vga_snapshot_pkg.sv
// ---------------------------------------------------------------------------
// vga_snapshot_pkg
// Shared definitions for the VGA snapshot block: debounce state encoding,
// register-bank width and the common 16-bit data word.
// ---------------------------------------------------------------------------
package vga_snapshot_pkg;

   localparam int REG_BANK_W = 176;   // 11 registers x 16 bit
   localparam int DATA_W     = 16;

   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic [1:0] {
      DB_IDLE,
      DB_PRESS,
      DB_HELD,
      DB_RELEASE
   } db_state_t;

endpackage

// File: rtl/vga_snapshot_if.sv
// ---------------------------------------------------------------------------
// vga_snapshot_if
// Bundles the live CPU state, VGA sync, freeze key and the frame-stable
// snapshot outputs.
//   master : drives vs/freezeKey/registerIn/pcIn/irIn, observes snapshots
//   slave  : the snapshot block itself
// ---------------------------------------------------------------------------
interface vga_snapshot_if;
   import vga_snapshot_pkg::*;

   logic                  vs;           // vertical sync, active low
   logic                  freezeKey;    // raw push-button, active high
   logic [REG_BANK_W-1:0] registerIn;   // live register bank
   word_t                 pcIn;         // live fetch PC
   word_t                 irIn;         // live fetch IR
   logic [REG_BANK_W-1:0] registerVGA;  // frame-stable register snapshot
   word_t                 IfPC;         // frame-stable PC snapshot
   word_t                 IfIR;         // frame-stable IR snapshot
   logic                  frozen;       // 1 = snapshot updates suppressed
   logic                  captured;     // one-cycle pulse per snapshot write
   word_t                 frameCount;   // count of vs falling edges

   modport master (
      output vs, freezeKey, registerIn, pcIn, irIn,
      input  registerVGA, IfPC, IfIR, frozen, captured, frameCount
   );

   modport slave (
      input  vs, freezeKey, registerIn, pcIn, irIn,
      output registerVGA, IfPC, IfIR, frozen, captured, frameCount
   );

endinterface

// File: rtl/vga_snapshot_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises a raw push-button and debounces it. A press is accepted once
// the synchronised level has stayed high long enough; acceptance produces a
// single-cycle toggle pulse. A held key produces exactly one pulse, and the
// key must be seen low for the same time before a new press is recognised.
//   clk    : system clock
//   rst    : synchronous active-low reset
//   key    : raw asynchronous key, active high
//   toggle : one-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module key_debounce
   import vga_snapshot_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic toggle
);

   localparam word_t CNT_LAST = word_t'(DEBOUNCE_CYCLES - 1);

   logic      key_meta;
   logic      key_sync;
   db_state_t state, state_nxt;
   word_t     db_cnt, db_cnt_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_meta <= 1'b0;
         key_sync <= 1'b0;
         state    <= DB_IDLE;
         db_cnt   <= '0;
      end else begin
         key_meta <= key;
         key_sync <= key_meta;
         state    <= state_nxt;
         db_cnt   <= db_cnt_nxt;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      db_cnt_nxt = db_cnt;
      toggle     = 1'b0;
      unique case (state)
         DB_IDLE: begin
            if (key_sync) begin
               state_nxt  = DB_PRESS;
               db_cnt_nxt = '0;
            end
         end
         DB_PRESS: begin
            if (!key_sync) begin
               state_nxt = DB_IDLE;
            end else if (db_cnt == CNT_LAST) begin
               state_nxt = DB_HELD;
               toggle    = 1'b1;
            end else begin
               db_cnt_nxt = db_cnt + 1'b1;
            end
         end
         DB_HELD: begin
            if (!key_sync) begin
               state_nxt  = DB_RELEASE;
               db_cnt_nxt = '0;
            end
         end
         DB_RELEASE: begin
            // A bounce back high while releasing is still the same press.
            if (key_sync) begin
               state_nxt = DB_HELD;
            end else if (db_cnt == CNT_LAST) begin
               state_nxt = DB_IDLE;
            end else begin
               db_cnt_nxt = db_cnt + 1'b1;
            end
         end
         default: state_nxt = DB_IDLE;
      endcase
   end

endmodule

// File: rtl/vga_snapshot.sv
// ---------------------------------------------------------------------------
// vga_snapshot
// Captures the live CPU register bank, PC and IR once every FRAME_DIV frames
// (on the vs falling edge) so the renderer sees values that are stable for a
// whole frame. A debounced freeze key toggles suppression of the capture.
//   clk : system clock (same as the VGA timing engine)
//   rst : synchronous active-low reset
//   bus : vga_snapshot_if.slave -- sync/key/live inputs, snapshot outputs,
//         frozen, captured pulse and frame counter
// ---------------------------------------------------------------------------
module vga_snapshot
   import vga_snapshot_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FRAME_DIV       = 1     // 1..255
) (
   input  logic           clk,
   input  logic           rst,
   vga_snapshot_if.slave  bus
);

   localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

   logic                  vs_q;
   logic                  frame_start;
   logic [7:0]            div_cnt;
   logic                  toggle;
   logic                  capture;
   logic                  frozen_q;
   logic                  captured_q;
   word_t                 frame_cnt;
   word_t                 pc_snap;
   word_t                 ir_snap;
   logic [REG_BANK_W-1:0] reg_snap;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk    (clk),
      .rst    (rst),
      .key    (bus.freezeKey),
      .toggle (toggle)
   );

   // Falling edge of vs; a long low pulse yields a single event.
   assign frame_start = vs_q & ~bus.vs;

   // Uses frozen before any same-cycle toggle, so a press that lands on a
   // frame start still gets that frame captured.
   assign capture = frame_start & (div_cnt == DIV_LAST) & ~frozen_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         // vs idles high, so the edge detector starts from the idle level.
         vs_q       <= 1'b1;
         div_cnt    <= '0;
         frame_cnt  <= '0;
         frozen_q   <= 1'b0;
         captured_q <= 1'b0;
         // NOTE: the snapshot bank is ordinary flops, not a RAM, so it is
         // reset along with the control state and the renderer never sees X.
         reg_snap   <= '0;
         pc_snap    <= '0;
         ir_snap    <= '0;
      end else begin
         vs_q       <= bus.vs;
         captured_q <= capture;
         if (frame_start) begin
            frame_cnt <= frame_cnt + 1'b1;
            div_cnt   <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
         end
         if (toggle) begin
            frozen_q <= ~frozen_q;
         end
         if (capture) begin
            reg_snap <= bus.registerIn;
            pc_snap  <= bus.pcIn;
            ir_snap  <= bus.irIn;
         end
      end
   end

   assign bus.registerVGA = reg_snap;
   assign bus.IfPC        = pc_snap;
   assign bus.IfIR        = ir_snap;
   assign bus.frozen      = frozen_q;
   assign bus.captured    = captured_q;
   assign bus.frameCount  = frame_cnt;

endmodule

// File: tb/tb_vga_snapshot.sv
// ---------------------------------------------------------------------------
// tb_vga_snapshot
// Two instances (FRAME_DIV = 1 and 3, DEBOUNCE_CYCLES = 16) share one set of
// directed stimulus. A frame-level model predicts every output each cycle;
// literal expectations pin key points of each scenario.
// ---------------------------------------------------------------------------
module tb_vga_snapshot;
   import vga_snapshot_pkg::*;

   localparam int DEB   = 16;
   localparam int DIV_A = 1;
   localparam int DIV_B = 3;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  vs = 1'b1;
   logic                  freeze_key = 1'b0;
   logic [REG_BANK_W-1:0] reg_in = '0;
   word_t                 pc_in = '0;
   word_t                 ir_in = '0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vga_snapshot_if if_a ();
   vga_snapshot_if if_b ();

   assign if_a.vs = vs;          assign if_b.vs = vs;
   assign if_a.freezeKey = freeze_key; assign if_b.freezeKey = freeze_key;
   assign if_a.registerIn = reg_in;    assign if_b.registerIn = reg_in;
   assign if_a.pcIn = pc_in;     assign if_b.pcIn = pc_in;
   assign if_a.irIn = ir_in;     assign if_b.irIn = ir_in;

   vga_snapshot #(.DEBOUNCE_CYCLES(DEB), .FRAME_DIV(DIV_A)) dut_a (
      .clk (clk), .rst (rst), .bus (if_a.slave));
   vga_snapshot #(.DEBOUNCE_CYCLES(DEB), .FRAME_DIV(DIV_B)) dut_b (
      .clk (clk), .rst (rst), .bus (if_b.slave));

   task automatic check(input string name, input logic [175:0] act,
                        input logic [175:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Key: the synchronised key is the raw key two clocks late. The accepted
   // level flips once the synchronised key has disagreed with it for DEB+1
   // consecutive samples; a flip to 1 is a press and toggles frozen.
   logic                  m_vs_prev, m_kd1, m_kd2, m_lvl, m_frozen;
   int                    m_run, m_nfs;
   word_t                 m_fc;
   logic [REG_BANK_W-1:0] m_reg [2];
   word_t                 m_pc [2];
   word_t                 m_ir [2];
   logic                  m_cap [2];

   task automatic model_step();
      logic fs, tog;
      int   div;
      if (!rst) begin
         m_vs_prev = 1'b1; m_kd1 = 1'b0; m_kd2 = 1'b0; m_lvl = 1'b0;
         m_frozen = 1'b0; m_run = 0; m_nfs = 0; m_fc = '0;
         for (int i = 0; i < 2; i++) begin
            m_reg[i] = '0; m_pc[i] = '0; m_ir[i] = '0; m_cap[i] = 1'b0;
         end
      end else begin
         fs  = m_vs_prev && !vs;
         tog = 1'b0;
         if (m_kd2 != m_lvl) begin
            m_run++;
            if (m_run == DEB + 1) begin
               m_lvl = m_kd2;
               m_run = 0;
               tog   = m_kd2;
            end
         end else begin
            m_run = 0;
         end
         for (int i = 0; i < 2; i++) begin
            div      = (i == 0) ? DIV_A : DIV_B;
            m_cap[i] = 1'b0;
            if (fs && ((m_nfs + 1) % div == 0) && !m_frozen) begin
               m_reg[i] = reg_in; m_pc[i] = pc_in; m_ir[i] = ir_in;
               m_cap[i] = 1'b1;
            end
         end
         if (fs) begin
            m_nfs++;
            m_fc = m_fc + 16'd1;
         end
         if (tog) m_frozen = !m_frozen;
         m_vs_prev = vs;
         m_kd2 = m_kd1;
         m_kd1 = freeze_key;
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      check("a.registerVGA", if_a.registerVGA, m_reg[0]);
      check("a.IfPC", 176'(if_a.IfPC), 176'(m_pc[0]));
      check("a.IfIR", 176'(if_a.IfIR), 176'(m_ir[0]));
      check("a.captured", 176'(if_a.captured), 176'(m_cap[0]));
      check("a.frozen", 176'(if_a.frozen), 176'(m_frozen));
      check("a.frameCount", 176'(if_a.frameCount), 176'(m_fc));
      check("b.registerVGA", if_b.registerVGA, m_reg[1]);
      check("b.IfPC", 176'(if_b.IfPC), 176'(m_pc[1]));
      check("b.IfIR", 176'(if_b.IfIR), 176'(m_ir[1]));
      check("b.captured", 176'(if_b.captured), 176'(m_cap[1]));
      check("b.frozen", 176'(if_b.frozen), 176'(m_frozen));
      check("b.frameCount", 176'(if_b.frameCount), 176'(m_fc));
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
   endtask

   task automatic frame(input int hi);
      vs = 1'b0;
      tick(1);
      vs = 1'b1;
      tick(hi);
   endtask

   initial begin
      // Reset state and first capture.
      tick(1);
      do_reset();
      check("rst a.registerVGA", if_a.registerVGA, 176'd0);
      check("rst a.frameCount", 176'(if_a.frameCount), 176'd0);
      check("rst a.frozen", 176'(if_a.frozen), 176'd0);
      reg_in = {11{16'h1234}};
      pc_in  = 16'h0040;
      ir_in  = 16'hBEEF;
      tick(2);
      vs = 1'b0;
      tick(1);
      check("t1 a.registerVGA", if_a.registerVGA, {11{16'h1234}});
      check("t1 a.IfPC", 176'(if_a.IfPC), 176'(16'h0040));
      check("t1 a.captured", 176'(if_a.captured), 176'd1);
      check("t1 a.frameCount", 176'(if_a.frameCount), 176'd1);
      check("t1 b.IfPC", 176'(if_b.IfPC), 176'd0);
      // vs held low: no further frame starts.
      tick(4);
      check("t1 held-low a.captured", 176'(if_a.captured), 176'd0);
      check("t1 held-low a.frameCount", 176'(if_a.frameCount), 176'd1);
      vs = 1'b1;
      tick(2);

      // Frame divider: only every third frame captured by instance b.
      do_reset();
      tick(2);
      for (int f = 1; f <= 6; f++) begin
         pc_in = 16'(f);
         ir_in = 16'(f + 256);
         frame(2);
         if (f == 2) check("t2 b.IfPC f2", 176'(if_b.IfPC), 176'd0);
         if (f == 3) check("t2 b.IfPC f3", 176'(if_b.IfPC), 176'd3);
         if (f == 5) check("t2 b.IfPC f5", 176'(if_b.IfPC), 176'd3);
      end
      check("t2 b.IfPC f6", 176'(if_b.IfPC), 176'd6);
      check("t2 a.IfPC f6", 176'(if_a.IfPC), 176'd6);

      // Bouncy key then a solid hold: one toggle, snapshots frozen.
      do_reset();
      tick(2);
      ir_in = 16'hAAAA;
      frame(2);
      for (int b = 0; b < 3; b++) begin
         freeze_key = 1'b1; tick(5);
         freeze_key = 1'b0; tick(2);
      end
      freeze_key = 1'b1;
      tick(40);
      check("t3 a.frozen", 176'(if_a.frozen), 176'd1);
      freeze_key = 1'b0;
      tick(30);
      check("t3 a.frozen after release", 176'(if_a.frozen), 176'd1);
      ir_in = 16'h5555;
      for (int f = 0; f < 3; f++) frame(2);
      check("t3 a.IfIR", 176'(if_a.IfIR), 176'(16'hAAAA));
      check("t3 b.IfIR", 176'(if_b.IfIR), 176'd0);
      check("t3 a.frameCount", 176'(if_a.frameCount), 176'd4);

      // Toggle coincident with frame start: that frame is still captured.
      do_reset();
      tick(4);
      pc_in = 16'h0ABC;
      freeze_key = 1'b1;
      tick(18);
      vs = 1'b0;
      tick(1);
      vs = 1'b1;
      check("t4 a.captured", 176'(if_a.captured), 176'd1);
      check("t4 a.IfPC", 176'(if_a.IfPC), 176'(16'h0ABC));
      check("t4 a.frozen", 176'(if_a.frozen), 176'd1);

      // Reset while a new press is being debounced and frozen is set.
      freeze_key = 1'b0;
      tick(25);
      freeze_key = 1'b1;
      tick(6);
      rst = 1'b0;
      freeze_key = 1'b0;
      tick(1);
      check("t5 a.frozen", 176'(if_a.frozen), 176'd0);
      check("t5 a.registerVGA", if_a.registerVGA, 176'd0);
      check("t5 a.IfPC", 176'(if_a.IfPC), 176'd0);
      check("t5 a.frameCount", 176'(if_a.frameCount), 176'd0);
      rst = 1'b1;
      tick(1);
      check("t5 a.frameCount post", 176'(if_a.frameCount), 176'd0);
      pc_in = 16'h0077;
      frame(2);
      frame(2);
      check("t5 b.IfPC f2", 176'(if_b.IfPC), 176'd0);
      frame(2);
      check("t5 b.IfPC f3", 176'(if_b.IfPC), 176'(16'h0077));

      // Frame counter wrap.
      do_reset();
      tick(1);
      for (int f = 0; f < 65535; f++) frame(1);
      check("t6 a.frameCount max", 176'(if_a.frameCount), 176'(16'hFFFF));
      frame(1);
      check("t6 a.frameCount wrap", 176'(if_a.frameCount), 176'd0);
      check("t6 b.frameCount wrap", 176'(if_b.frameCount), 176'd0);

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_snapshot.md
VGA_SNAPSHOT -- requirements
Module: vga_snapshot

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, cycles a key level must hold before it is accepted (synthesis value 50000).
REQ-002 Parameter: FRAME_DIV, default 1, capture once every FRAME_DIV frames (range 1..255).
REQ-003 Port: clk  in  1  system clock, same clock as the VGA timing engine.
REQ-004 Port: rst  in  1  synchronous, active-low reset.
REQ-005 Port: vs  in  1  vertical sync from the timing engine, active-low pulse, synchronous to clk.
REQ-006 Port: freezeKey  in  1  raw freeze push-button, active high, asynchronous.
REQ-007 Port: registerIn  in  176  live CPU register bank, 11 x 16 bit.
REQ-008 Port: pcIn  in  16  live fetch PC.
REQ-009 Port: irIn  in  16  live fetch IR.
REQ-010 Port: registerVGA  out  176  frame-stable register snapshot for the renderer.
REQ-011 Port: IfPC  out  16  frame-stable PC snapshot.
REQ-012 Port: IfIR  out  16  frame-stable IR snapshot.
REQ-013 Port: frozen  out  1  1 = snapshot updates suppressed.
REQ-014 Port: captured  out  1  one-cycle pulse on each cycle a snapshot is written.
REQ-015 Port: frameCount  out  16  count of vs falling edges.

Function
REQ-016 vsQ is a register sampling vs every cycle; frameStart = vsQ & ~vs (combinational).
REQ-017 frameCount increments by 1 on every frameStart, independent of frozen, and wraps 0xFFFF -> 0x0000.
REQ-018 divCnt counts frameStart events 0..FRAME_DIV-1; at FRAME_DIV-1 plus frameStart it returns to 0; it advances while frozen.
REQ-019 Capture condition: frameStart & (divCnt == FRAME_DIV-1) & ~frozen.
REQ-020 On capture, registerVGA/IfPC/IfIR load registerIn/pcIn/irIn at that clock edge; captured = 1 for exactly the following cycle; outputs hold otherwise.
REQ-021 Latency: snapshot outputs are visible one clock after the first cycle on which vs is sampled low.
REQ-022 freezeKey passes through a 2-flop synchronizer (keySync) before use.
REQ-023 Debounce FSM states: DB_IDLE, DB_PRESS, DB_HELD, DB_RELEASE; 16-bit counter dbCnt.
REQ-024 DB_IDLE: keySync=1 -> DB_PRESS, dbCnt=0.
REQ-025 DB_PRESS: keySync=0 -> DB_IDLE; dbCnt==DEBOUNCE_CYCLES-1 -> DB_HELD and a one-cycle toggle pulse; else dbCnt+1.
REQ-026 DB_HELD: keySync=0 -> DB_RELEASE, dbCnt=0.
REQ-027 DB_RELEASE: keySync=1 -> DB_HELD; dbCnt==DEBOUNCE_CYCLES-1 -> DB_IDLE; else dbCnt+1.
REQ-028 frozen inverts on each toggle pulse; a held key yields exactly one toggle.
REQ-029 Toggle and capture in the same cycle: the capture uses the pre-toggle frozen value, so a capture still occurs when going running -> frozen.
REQ-030 A vs low pulse of a single cycle still produces exactly one frameStart; vs held low produces no further frameStart.

Reset
REQ-031 While rst=0 at a clock edge: registerVGA, IfPC, IfIR, frameCount, divCnt, dbCnt = 0; frozen = 0; captured = 0; debounce FSM = DB_IDLE; synchronizer flops = 0; vsQ = 1 (no false frameStart after reset).
REQ-032 Reset mid-debounce or mid-frame aborts all activity; the first capture after release occurs on the FRAME_DIV-th frameStart.

Structure
REQ-033 The shared package holds the debounce state encoding, REG_BANK_W = 176 and the 16-bit data-width constant.
REQ-034 Debounce (synchronizer + FSM + dbCnt) is a sub-module named key_debounce with a single-cycle toggle output.

Verification
REQ-035 Reset, then vs 1->0 with registerIn = 176'h1234 repeated and pcIn = 16'h0040 -> registerVGA equals that pattern and IfPC = 16'h0040 one clock later; captured pulses once; frameCount = 1.
REQ-036 FRAME_DIV = 3, 6 frames with pcIn = frame index -> captures only on frames 3 and 6; IfPC = 3, then 6.
REQ-037 DEBOUNCE_CYCLES = 16; freezeKey bounces (5 cycles high, 2 low) and is then held 40 cycles -> exactly one toggle, frozen = 1; next frames leave IfIR unchanged while frameCount keeps incrementing.
REQ-038 Toggle pulse coincident with frameStart -> capture occurs and frozen = 1 afterwards.
REQ-039 frameCount preloaded to 0xFFFF by running 65535 frames -> the next frameStart gives 0x0000.
REQ-040 Assert rst for 1 cycle in DB_PRESS with frozen = 1 -> frozen = 0, outputs = 0, and no frameStart on the cycle after reset while vs = 0.
